// File: rtl/gpio_pad_ctrl.sv
// Purpose : GPIO / pad-attribute controller with shadowed per-pad config, atomic commit,
//           input synchronisers, per-pad edge flags and a level interrupt.
// Latency : writes take effect at the sampling edge; reads return one cycle after the strobe.
// Backpr. : none -- the bus accepts a read and/or write every cycle, there is no stall.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   bus_addr_i/wdata_i     register address and write data (pad regs 0..NUM_PADS-1, CTRL at NUM_PADS)
//   bus_we_i/bus_re_i      single-cycle write / read strobes
//   bus_rdata_o/rvalid_o   registered read data and its one-cycle valid pulse
//   pad_in_i               asynchronous pad inputs
//   pad_out_o              pad output data
//   pad_{oe,ie,sl,cs,pu,pd}_o  active pad attributes
//   irq_o                  level interrupt: irq_en & any edge flag
module gpio_pad_ctrl #(
    parameter int NUM_PADS    = 43,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = $clog2(NUM_PADS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   bus_addr_i,
    input  logic [7:0]          bus_wdata_i,
    input  logic                bus_we_i,
    input  logic                bus_re_i,
    output logic [7:0]          bus_rdata_o,
    output logic                bus_rvalid_o,
    input  logic [NUM_PADS-1:0] pad_in_i,
    output logic [NUM_PADS-1:0] pad_out_o,
    output logic [NUM_PADS-1:0] pad_oe_o,
    output logic [NUM_PADS-1:0] pad_ie_o,
    output logic [NUM_PADS-1:0] pad_sl_o,
    output logic [NUM_PADS-1:0] pad_cs_o,
    output logic [NUM_PADS-1:0] pad_pu_o,
    output logic [NUM_PADS-1:0] pad_pd_o,
    output logic                irq_o
);

    // Config byte layout: [0]OE [1]IE [2]SL [3]CS [4]PU [5]PD
    localparam logic [5:0]        CFG_RST   = 6'b00_0010;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_PADS);

    logic [5:0]          cfg_sh_q  [NUM_PADS];
    logic [5:0]          cfg_sh_d  [NUM_PADS];
    logic [5:0]          cfg_act_q [NUM_PADS];
    logic [5:0]          cfg_act_d [NUM_PADS];
    logic [NUM_PADS-1:0] out_q, out_d;
    logic [NUM_PADS-1:0] flag_q, flag_d;
    logic [NUM_PADS-1:0] prev_q, prev_d;
    logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PADS-1:0] sync_d [SYNC_STAGES];
    logic                irq_en_q, irq_en_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    logic [NUM_PADS-1:0] pad_sel;
    logic [NUM_PADS-1:0] ie_act;
    logic [NUM_PADS-1:0] in_gated;
    logic [NUM_PADS-1:0] edge_set;
    logic                ctrl_sel;
    logic                commit;
    logic                pending;

    assign ctrl_sel = (bus_addr_i == CTRL_ADDR);
    assign commit   = bus_we_i & ctrl_sel & bus_wdata_i[0];

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        assign pad_sel[g]  = (bus_addr_i == ADDR_W'(g));
        assign ie_act[g]   = cfg_act_q[g][1];
        assign pad_oe_o[g] = cfg_act_q[g][0];
        assign pad_ie_o[g] = cfg_act_q[g][1];
        assign pad_sl_o[g] = cfg_act_q[g][2];
        assign pad_cs_o[g] = cfg_act_q[g][3];
        assign pad_pu_o[g] = cfg_act_q[g][4];
        assign pad_pd_o[g] = cfg_act_q[g][5];
    end

    // A disabled input buffer reads as 0 and cannot raise an edge flag. The edge
    // compare uses the raw synced value so enabling IE on a steady-high pin does not
    // fabricate an edge.
    assign in_gated = sync_q[SYNC_STAGES-1] & ie_act;
    assign edge_set = ie_act & (sync_q[SYNC_STAGES-1] ^ prev_q);

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < NUM_PADS; i++) begin
            pending = pending | (cfg_sh_q[i] != cfg_act_q[i]);
        end
    end

    // Next-state for config, output data, flags and synchronisers
    always_comb begin
        cfg_sh_d  = cfg_sh_q;
        cfg_act_d = cfg_act_q;
        out_d     = out_q;
        flag_d    = flag_q;
        irq_en_d  = irq_en_q;
        prev_d    = sync_q[SYNC_STAGES-1];
        sync_d[0] = pad_in_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end

        for (int i = 0; i < NUM_PADS; i++) begin
            if (bus_we_i && pad_sel[i]) begin
                cfg_sh_d[i] = bus_wdata_i[5:0];
                out_d[i]    = bus_wdata_i[6];
            end
            // W1C loses to a simultaneous new edge so no event is dropped
            flag_d[i] = (flag_q[i] & ~(bus_we_i & pad_sel[i] & bus_wdata_i[7])) | edge_set[i];
        end

        if (bus_we_i && ctrl_sel) begin
            irq_en_d = bus_wdata_i[1];
        end
        if (commit) begin
            cfg_act_d = cfg_sh_q;
        end
    end

    // Read mux samples pre-write state, so a same-cycle write to the read address is not seen
    always_comb begin
        rdata_d  = '0;
        rvalid_d = bus_re_i;
        if (bus_re_i) begin
            if (ctrl_sel) begin
                rdata_d = {5'b0, pending, irq_en_q, 1'b0};
            end
            for (int i = 0; i < NUM_PADS; i++) begin
                if (pad_sel[i]) begin
                    rdata_d = {flag_q[i], in_gated[i], cfg_sh_q[i]};
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                cfg_sh_q[i]  <= CFG_RST;
                cfg_act_q[i] <= CFG_RST;
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            out_q    <= '0;
            flag_q   <= '0;
            prev_q   <= '0;
            irq_en_q <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            cfg_sh_q  <= cfg_sh_d;
            cfg_act_q <= cfg_act_d;
            sync_q    <= sync_d;
            out_q     <= out_d;
            flag_q    <= flag_d;
            prev_q    <= prev_d;
            irq_en_q  <= irq_en_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign pad_out_o    = out_q;
    assign bus_rdata_o  = rdata_q;
    assign bus_rvalid_o = rvalid_q;
    assign irq_o        = irq_en_q & (|flag_q);

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Purpose : directed bench for gpio_pad_ctrl (43 pads, 2 sync stages).
// Latency : inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Backpr. : n/a.
module tb_gpio_pad_ctrl;

    localparam int NP   = 43;
    localparam int AW   = 6;
    localparam logic [AW-1:0] CTRL = 6'd43;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] bus_addr_i;
    logic [7:0]    bus_wdata_i;
    logic          bus_we_i;
    logic          bus_re_i;
    logic [7:0]    bus_rdata_o;
    logic          bus_rvalid_o;
    logic [NP-1:0] pad_in_i;
    logic [NP-1:0] pad_out_o, pad_oe_o, pad_ie_o, pad_sl_o, pad_cs_o, pad_pu_o, pad_pd_o;
    logic          irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_pad_ctrl #(.NUM_PADS(NP), .SYNC_STAGES(2), .ADDR_W(AW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus_addr_i   (bus_addr_i),
        .bus_wdata_i  (bus_wdata_i),
        .bus_we_i     (bus_we_i),
        .bus_re_i     (bus_re_i),
        .bus_rdata_o  (bus_rdata_o),
        .bus_rvalid_o (bus_rvalid_o),
        .pad_in_i     (pad_in_i),
        .pad_out_o    (pad_out_o),
        .pad_oe_o     (pad_oe_o),
        .pad_ie_o     (pad_ie_o),
        .pad_sl_o     (pad_sl_o),
        .pad_cs_o     (pad_cs_o),
        .pad_pu_o     (pad_pu_o),
        .pad_pd_o     (pad_pd_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        bus_addr_i  = a;
        bus_wdata_i = d;
        bus_we_i    = 1'b1;
        tick();
        bus_we_i    = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [7:0] d, output logic v);
        bus_addr_i = a;
        bus_re_i   = 1'b1;
        tick();
        bus_re_i   = 1'b0;
        d = bus_rdata_o;
        v = bus_rvalid_o;
    endtask

    task automatic test_reset();
        logic [NP-1:0] ones;
        ones = '1;
        // state straight after power-on reset
        n_tests++;
        if (pad_ie_o !== ones || pad_oe_o !== '0 || pad_out_o !== '0) begin
            $display("FAIL reset_init_pads: ie=%h oe=%h out=%h required ie=%h oe=0 out=0",
                     pad_ie_o, pad_oe_o, pad_out_o, ones);
            n_fail++;
        end
        n_tests++;
        if (bus_rvalid_o !== 1'b0 || bus_rdata_o !== 8'h00 || irq_o !== 1'b0) begin
            $display("FAIL reset_init_bus: rvalid=%b rdata=%h irq=%b required 0/00/0",
                     bus_rvalid_o, bus_rdata_o, irq_o);
            n_fail++;
        end
        // disturb state, then reset mid-read without a clock edge
        wr(6'd0, 8'h41);
        wr(CTRL, 8'h01);
        n_tests++;
        if (pad_oe_o[0] !== 1'b1 || pad_out_o[0] !== 1'b1 || pad_ie_o[0] !== 1'b0) begin
            $display("FAIL reset_precond: oe0=%b out0=%b ie0=%b required 1/1/0",
                     pad_oe_o[0], pad_out_o[0], pad_ie_o[0]);
            n_fail++;
        end
        bus_addr_i = 6'd0;
        bus_re_i   = 1'b1;
        tick();
        n_tests++;
        if (bus_rvalid_o !== 1'b1) begin
            $display("FAIL reset_precond_rvalid: got %b required 1", bus_rvalid_o);
            n_fail++;
        end
        #2 rst_i = 1'b1;
        #1;
        n_tests++;
        if (pad_oe_o !== '0 || pad_ie_o !== ones || pad_out_o !== '0) begin
            $display("FAIL reset_async_pads: oe=%h ie=%h out=%h required 0/%h/0",
                     pad_oe_o, pad_ie_o, pad_out_o, ones);
            n_fail++;
        end
        n_tests++;
        if (bus_rvalid_o !== 1'b0 || bus_rdata_o !== 8'h00 || irq_o !== 1'b0) begin
            $display("FAIL reset_async_bus: rvalid=%b rdata=%h irq=%b required 0/00/0",
                     bus_rvalid_o, bus_rdata_o, irq_o);
            n_fail++;
        end
        bus_re_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_shadow_commit();
        logic [7:0]    d;
        logic          v;
        logic [NP-1:0] exp_oe, exp_ie, exp_pp;
        exp_oe = '0; exp_oe[5] = 1'b1; exp_oe[42] = 1'b1;
        exp_ie = '1; exp_ie[42] = 1'b0;
        exp_pp = '0; exp_pp[42] = 1'b1;
        wr(6'd5, 8'h03);
        wr(6'd42, 8'h31);
        n_tests++;
        if (pad_oe_o !== '0 || pad_pu_o !== '0 || pad_pd_o !== '0) begin
            $display("FAIL shadow_no_effect: oe=%h pu=%h pd=%h required all 0", pad_oe_o, pad_pu_o, pad_pd_o);
            n_fail++;
        end
        rd(CTRL, d, v);
        n_tests++;
        if (d !== 8'h04 || v !== 1'b1) begin
            $display("FAIL ctrl_pending: rdata=%h rvalid=%b required 04/1", d, v);
            n_fail++;
        end
        rd(6'd5, d, v);
        n_tests++;
        if (d !== 8'h03) begin
            $display("FAIL shadow_readback: rdata=%h required 03", d);
            n_fail++;
        end
        wr(CTRL, 8'h01);
        n_tests++;
        if (pad_oe_o !== exp_oe || pad_ie_o !== exp_ie) begin
            $display("FAIL commit_oe_ie: oe=%h ie=%h required %h/%h", pad_oe_o, pad_ie_o, exp_oe, exp_ie);
            n_fail++;
        end
        n_tests++;
        if (pad_pu_o !== exp_pp || pad_pd_o !== exp_pp || pad_sl_o !== '0 || pad_cs_o !== '0) begin
            $display("FAIL commit_pu_pd: pu=%h pd=%h sl=%h cs=%h required pu=pd=%h sl=cs=0",
                     pad_pu_o, pad_pd_o, pad_sl_o, pad_cs_o, exp_pp);
            n_fail++;
        end
        rd(CTRL, d, v);
        n_tests++;
        if (d !== 8'h00) begin
            $display("FAIL ctrl_after_commit: rdata=%h required 00", d);
            n_fail++;
        end
    endtask

    task automatic test_output_data();
        logic [7:0]    d;
        logic          v;
        logic [NP-1:0] exp_out;
        exp_out = '0; exp_out[7] = 1'b1;
        wr(6'd7, 8'h42);
        n_tests++;
        if (pad_out_o !== exp_out) begin
            $display("FAIL out_data: pad_out=%h required %h", pad_out_o, exp_out);
            n_fail++;
        end
        pad_in_i[7] = 1'b1;
        rd(6'd7, d, v);
        n_tests++;
        if (d !== 8'h02) begin
            $display("FAIL in_sync_n: rdata=%h required 02", d);
            n_fail++;
        end
        rd(6'd7, d, v);
        n_tests++;
        if (d !== 8'h02) begin
            $display("FAIL in_sync_n1: rdata=%h required 02", d);
            n_fail++;
        end
        rd(6'd7, d, v);
        n_tests++;
        if (d !== 8'h42) begin
            $display("FAIL in_sync_n2: rdata=%h required 42", d);
            n_fail++;
        end
        rd(6'd7, d, v);
        n_tests++;
        if (d !== 8'hC2) begin
            $display("FAIL in_flag_n3: rdata=%h required c2", d);
            n_fail++;
        end
        wr(6'd7, 8'hC2);
    endtask

    task automatic test_edge_irq();
        logic [7:0] d;
        logic       v;
        wr(CTRL, 8'h02);
        n_tests++;
        if (irq_o !== 1'b0) begin
            $display("FAIL irq_idle: irq=%b required 0", irq_o);
            n_fail++;
        end
        pad_in_i[12] = 1'b1;
        tick();
        tick();
        n_tests++;
        if (irq_o !== 1'b0) begin
            $display("FAIL irq_early: irq=%b required 0 after edge N+1", irq_o);
            n_fail++;
        end
        tick();
        n_tests++;
        if (irq_o !== 1'b1) begin
            $display("FAIL irq_set: irq=%b required 1 after edge N+2", irq_o);
            n_fail++;
        end
        rd(6'd12, d, v);
        n_tests++;
        if (d !== 8'hC2) begin
            $display("FAIL flag_read: rdata=%h required c2", d);
            n_fail++;
        end
        wr(6'd12, 8'h82);
        n_tests++;
        if (irq_o !== 1'b0) begin
            $display("FAIL w1c_clear: irq=%b required 0", irq_o);
            n_fail++;
        end
        wr(6'd12, 8'h00);
        wr(CTRL, 8'h03);
        n_tests++;
        if (pad_ie_o[12] !== 1'b0) begin
            $display("FAIL ie_off_commit: ie12=%b required 0", pad_ie_o[12]);
            n_fail++;
        end
        pad_in_i[12] = 1'b0;
        repeat (4) tick();
        n_tests++;
        if (irq_o !== 1'b0) begin
            $display("FAIL ie_off_no_irq: irq=%b required 0", irq_o);
            n_fail++;
        end
        pad_in_i[12] = 1'b1;
        repeat (4) tick();
        rd(6'd12, d, v);
        n_tests++;
        if (d !== 8'h00 || irq_o !== 1'b0) begin
            $display("FAIL ie_off_forced0: rdata=%h irq=%b required 00/0", d, irq_o);
            n_fail++;
        end
    endtask

    task automatic test_collision();
        logic [7:0] d;
        logic       v;
        pad_in_i[3] = 1'b1;
        tick();
        tick();
        wr(6'd3, 8'h82);
        n_tests++;
        if (irq_o !== 1'b1) begin
            $display("FAIL collision_irq: irq=%b required 1", irq_o);
            n_fail++;
        end
        rd(6'd3, d, v);
        n_tests++;
        if (d !== 8'hC2) begin
            $display("FAIL collision_flag: rdata=%h required c2", d);
            n_fail++;
        end
        wr(6'd3, 8'h82);
        n_tests++;
        if (irq_o !== 1'b0) begin
            $display("FAIL collision_clear: irq=%b required 0", irq_o);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       v;
        bus_addr_i  = 6'd9;
        bus_wdata_i = 8'h05;
        bus_we_i    = 1'b1;
        bus_re_i    = 1'b1;
        tick();
        bus_we_i    = 1'b0;
        bus_re_i    = 1'b0;
        n_tests++;
        if (bus_rdata_o !== 8'h02 || bus_rvalid_o !== 1'b1) begin
            $display("FAIL rw_same_cycle: rdata=%h rvalid=%b required 02/1", bus_rdata_o, bus_rvalid_o);
            n_fail++;
        end
        rd(6'd9, d, v);
        n_tests++;
        if (d !== 8'h05) begin
            $display("FAIL rw_after: rdata=%h required 05", d);
            n_fail++;
        end
        rd(6'd42, d, v);
        n_tests++;
        if (d !== 8'h31 || v !== 1'b1) begin
            $display("FAIL b2b_rd42: rdata=%h rvalid=%b required 31/1", d, v);
            n_fail++;
        end
        rd(6'd7, d, v);
        n_tests++;
        if (d !== 8'h42 || v !== 1'b1) begin
            $display("FAIL b2b_rd7: rdata=%h rvalid=%b required 42/1", d, v);
            n_fail++;
        end
    endtask

    task automatic test_addr_bounds();
        logic [7:0]    d;
        logic          v;
        logic [NP-1:0] exp_oe, exp_out;
        exp_oe  = '0; exp_oe[5] = 1'b1; exp_oe[42] = 1'b1;
        exp_out = '0; exp_out[7] = 1'b1;
        rd(6'd44, d, v);
        n_tests++;
        if (d !== 8'h00 || v !== 1'b1) begin
            $display("FAIL oob_read: rdata=%h rvalid=%b required 00/1", d, v);
            n_fail++;
        end
        tick();
        n_tests++;
        if (bus_rvalid_o !== 1'b0) begin
            $display("FAIL rvalid_pulse: rvalid=%b required 0", bus_rvalid_o);
            n_fail++;
        end
        wr(6'd44, 8'h00);
        wr(6'd63, 8'hFF);
        n_tests++;
        if (pad_oe_o !== exp_oe || pad_out_o !== exp_out) begin
            $display("FAIL oob_write_pads: oe=%h out=%h required %h/%h", pad_oe_o, pad_out_o, exp_oe, exp_out);
            n_fail++;
        end
        rd(CTRL, d, v);
        n_tests++;
        if (d !== 8'h06) begin
            $display("FAIL oob_write_ctrl: rdata=%h required 06", d);
            n_fail++;
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        bus_addr_i  = '0;
        bus_wdata_i = '0;
        bus_we_i    = 1'b0;
        bus_re_i    = 1'b0;
        pad_in_i    = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();
        test_reset();
        test_shadow_commit();
        test_output_data();
        test_edge_irq();
        test_collision();
        test_back_to_back();
        test_addr_bounds();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
